spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Receive-side counterpart to the LIF neuron: it turns a spike train back into an 8-bit value. It counts spike cycles over a programmable window and presents the saturated count as a rate sample on a valid/ready output. The block sits after a neuron's `spike` output and feeds downstream logic or the tile output pins.

## Interface

Parameters:
- `WINDOW_W`, default 8: width of the window-length input and the cycle timer.

Ports (clock and reset first):
- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `spike` input 1: spike level from the neuron, sampled every cycle.
- `enable` input 1: run windows while high.
- `window_len` input WINDOW_W: window length in cycles; latched at window start; 0 is treated as 1.
- `out_ready` input 1: downstream accepts the sample.
- `out_valid` output 1: `rate` holds an unaccepted sample.
- `rate` output 8: spike count of the last completed window, saturating at 255.
- `overrun` output 1: sticky flag; an unaccepted sample was overwritten.
- `min_isi` output 8: present only with `SPIKE_RATE_DECODER_ISI_EN`.

## Operation

- FSM states: IDLE, COUNT.
- IDLE → COUNT on the first cycle `enable`=1.
  - Latch `window_len` into `len_q`.
  - Clear the counter and the timer.
  - The `spike` value on this cycle is sample 0.
- COUNT, each cycle:
  - `count` += `spike`, saturating at 255.
  - `timer`++.
- Last sample cycle (`timer` == `len_q`−1):
  - Load `count`+`spike` (saturated) into `rate` and set `out_valid`.
  - If `enable`=1, start the next window on the following cycle with no gap, re-latching `window_len`.
  - If `enable`=0, return to IDLE.
- `enable`=0 before the last sample abandons the window: go to IDLE, produce no sample, leave `rate` and `out_valid` unchanged.
- Output handshake:
  - `out_valid` clears on the cycle after `out_valid`&`out_ready`.
  - `rate` stays stable while `out_valid`=1, unless overwritten.
- Boundary: new sample while `out_valid`=1 and `out_ready`=0. The new sample replaces `rate`, `out_valid` stays 1, and `overrun` is set.
- Boundary: new sample on the same cycle as a handshake. The new sample loads, `out_valid` stays 1, and `overrun` is not set.
- `overrun` clears only on reset.
- Arithmetic: the counter is 8 bits. A window longer than 255 cycles with continuous spikes yields 255.

## Timing

- Reset values: state IDLE, `rate`=0, `out_valid`=0, `overrun`=0, `min_isi`=255, internal counters 0.
- Reset asserted mid-window: the window is discarded, and the outputs take their reset values on the next edge.
- Latency: `out_valid` rises on the edge after the last sample cycle. The first sample appears `len_q`+1 cycles after `enable` rises.
- Throughput: one sample per `len_q` cycles; back-to-back windows have no dead cycle.
- `window_len` changes take effect only at the next window start.

## Configuration

- `SPIKE_RATE_DECODER_ISI_EN` defined:
  - Adds the `min_isi` output and logic.
  - Tracks the minimum count of cycles between consecutive spike samples within a window, saturating at 255.
  - Value is 255 if the window has fewer than 2 spikes.
  - Updated alongside `rate`, under the same valid/overrun rules.
- Undefined: no `min_isi` port, no ISI logic; behaviour is otherwise identical.

## Structure

- Shared package `snn_pkg`:
  - FSM state typedef.
  - `RATE_W`=8.
  - `RATE_MAX`=255.
  - `ISI_MAX`=255.
- One sub-module, `sat_counter`:
  - Parameterised width.
  - Has `clear`, increment, and saturation flag.
  - Instantiated for the spike count and, when enabled, the ISI counter.

## Test plan

- `window_len`=10, `spike` held 1, `enable` held 1 → `rate`=10 with `out_valid` at cycle 11; next sample at cycle 21.
- `spike` 1 every 4th cycle, `window_len`=16 → `rate`=4; with ISI enabled `min_isi`=4.
- `WINDOW_W`=10, `window_len`=300, `spike` held 1 → `rate`=255, with no wrap.
- `out_ready`=0 across two windows of 8 with constant spikes → `rate`=8, `overrun`=1 after the second window. Then `out_ready`=1 → `out_valid` clears the next cycle, and `overrun` stays 1.
- `window_len`=10, `enable` dropped at cycle 5 → no `out_valid`. Re-enable → fresh window, `rate` reflects only the new 10 cycles.
- `rst_n`=0 mid-window with `out_valid`=1 → `out_valid`=0, `rate`=0, `overrun`=0 next edge; state IDLE.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared SNN definitions: rate/ISI widths, saturation limits and the
// window-FSM state type used by the spike-rate decoder.
package snn_pkg;

    localparam int RATE_W   = 8;
    localparam int RATE_MAX = 255;
    localparam int ISI_MAX  = 255;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    // Smaller of two rate-width values; used when folding ISI candidates.
    function automatic logic [RATE_W-1:0] min_rate(input logic [RATE_W-1:0] a,
                                                   input logic [RATE_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones and
// reports saturation so callers can form saturated "next" values.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_sat
);

    logic [WIDTH-1:0] r_count;

    assign o_count = r_count;
    assign o_sat   = &r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_count <= '0;
        end else if (i_inc && !o_sat) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spike samples over a programmable window and emits the saturated
// count on a valid/ready output. SPIKE_RATE_DECODER_ISI_EN adds min_isi.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int WINDOW_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spike,
    input  logic                enable,
    input  logic [WINDOW_W-1:0] window_len,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [RATE_W-1:0]   rate,
    output logic                overrun
`ifdef SPIKE_RATE_DECODER_ISI_EN
    ,
    output logic [RATE_W-1:0]   min_isi
`endif
);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_start;
    logic                w_last;
    logic                w_in_count;

    logic [WINDOW_W-1:0] r_len;
    logic [WINDOW_W-1:0] r_timer;
    logic [WINDOW_W-1:0] w_len_eff;
    logic                r_spike;

    logic [RATE_W-1:0]   w_count;
    logic                w_count_sat;
    logic                w_count_inc;
    logic [RATE_W-1:0]   w_rate_next;

    // The window-start cycle's spike is sample 0; registering it lets that
    // cycle be spent latching the length and clearing the counters.
    assign w_in_count  = (r_state == ST_COUNT);
    assign w_len_eff   = (window_len == '0) ? WINDOW_W'(1) : window_len;
    assign w_count_inc = w_in_count & r_spike;
    assign w_rate_next = w_count_sat ? w_count : (w_count + RATE_W'(r_spike));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_start      = 1'b1;
                    w_state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (r_timer == r_len - WINDOW_W'(1)) begin
                    w_last = 1'b1;
                    if (enable) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (!enable) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_spike <= 1'b0;
            r_len   <= '0;
            r_timer <= '0;
        end else begin
            r_spike <= spike;
            if (w_start) begin
                r_len   <= w_len_eff;
                r_timer <= '0;
            end else if (w_in_count) begin
                r_timer <= r_timer + WINDOW_W'(1);
            end
        end
    end

    sat_counter #(
        .WIDTH   (RATE_W)
    ) u_count (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start),
        .i_inc   (w_count_inc),
        .o_count (w_count),
        .o_sat   (w_count_sat)
    );

    // A new sample always wins; overrun only when the old one was not taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rate      <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (w_last) begin
            rate      <= w_rate_next;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SPIKE_RATE_DECODER_ISI_EN
    logic              r_seen;
    logic [RATE_W-1:0] r_min_run;
    logic [RATE_W-1:0] w_isi_count;
    logic              w_isi_sat;
    logic              w_isi_clear;
    logic [RATE_W-1:0] w_isi_dist;
    logic [RATE_W-1:0] w_isi_cand;
    logic [RATE_W-1:0] w_min_next;

    // The gap counter restarts on every spike sample, so count+1 is the
    // distance from the previous spike sample to the current one.
    assign w_isi_clear = w_start | w_count_inc;
    assign w_isi_dist  = w_isi_sat ? w_isi_count : (w_isi_count + RATE_W'(1));
    assign w_isi_cand  = (w_count_inc && r_seen) ? w_isi_dist : RATE_W'(ISI_MAX);
    assign w_min_next  = min_rate(w_isi_cand, r_min_run);

    sat_counter #(
        .WIDTH   (RATE_W)
    ) u_isi (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_isi_clear),
        .i_inc   (w_in_count),
        .o_count (w_isi_count),
        .o_sat   (w_isi_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seen    <= 1'b0;
            r_min_run <= RATE_W'(ISI_MAX);
            min_isi   <= RATE_W'(ISI_MAX);
        end else begin
            if (w_start) begin
                r_seen    <= 1'b0;
                r_min_run <= RATE_W'(ISI_MAX);
            end else if (w_in_count) begin
                r_min_run <= w_min_next;
                if (r_spike) begin
                    r_seen <= 1'b1;
                end
            end
            if (w_last) begin
                min_isi <= w_min_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: stimulus pushes expected samples,
// a negedge monitor pops and compares them on each accepted handshake.
module tb_spike_rate_decoder;

    localparam int WW = 10;

    typedef struct {
        int rate;
        int isi;
        int cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          spike;
    logic          enable;
    logic [WW-1:0] window_len;
    logic          out_ready;
    logic          out_valid;
    logic [7:0]    rate;
    logic          overrun;
`ifdef SPIKE_RATE_DECODER_ISI_EN
    logic [7:0]    min_isi;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   base;
    exp_t sb[$];

    spike_rate_decoder #(
        .WINDOW_W   (WW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike      (spike),
        .enable     (enable),
        .window_len (window_len),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .rate       (rate),
        .overrun    (overrun)
`ifdef SPIKE_RATE_DECODER_ISI_EN
        ,
        .min_isi    (min_isi)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic en, input logic spk);
        enable = en;
        spike  = spk;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sample(input int r, input int isi, input int at);
        exp_t e;
        e.rate = r;
        e.isi  = isi;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Monitor: every accepted sample must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_sample", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rate", int'(rate), e.rate);
                check("sample_cycle", cyc, e.cyc);
`ifdef SPIKE_RATE_DECODER_ISI_EN
                check("min_isi", int'(min_isi), e.isi);
`endif
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        spike      = 1'b0;
        enable     = 1'b0;
        window_len = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", int'(out_valid), 0);
        check("reset_rate", int'(rate), 0);
        check("reset_overrun", int'(overrun), 0);
`ifdef SPIKE_RATE_DECODER_ISI_EN
        check("reset_min_isi", int'(min_isi), 255);
`endif
        rst_n = 1'b1;
        step(0, 0);

        // Back-to-back windows of 10 with constant spikes; mid-window length
        // changes must not affect the running window.
        out_ready = 1'b1;
        base = cyc;
        expect_sample(10, 1, base + 11);
        expect_sample(10, 1, base + 21);
        for (int i = 0; i <= 20; i++) begin
            window_len = (i >= 3 && i <= 7) ? WW'(3) : WW'(10);
            step(1, 1);
        end
        step(0, 0);
        repeat (3) step(0, 0);

        // window_len=0 behaves as 1: a new sample every cycle, each landing
        // on the same edge as the previous handshake, so no overrun.
        window_len = '0;
        base = cyc;
        expect_sample(1, 255, base + 2);
        expect_sample(0, 255, base + 3);
        expect_sample(1, 255, base + 4);
        expect_sample(1, 255, base + 5);
        step(1, 1);
        step(1, 0);
        step(1, 1);
        step(1, 1);
        step(0, 0);
        step(0, 0);
        check("len1_overrun", int'(overrun), 0);
        check("len1_valid_clear", int'(out_valid), 0);
        repeat (2) step(0, 0);

        // One spike every 4th cycle over 16 cycles.
        window_len = WW'(16);
        base = cyc;
        expect_sample(4, 4, base + 17);
        for (int i = 0; i < 16; i++) step(1, (i % 4) == 0);
        step(0, 0);
        repeat (3) step(0, 0);

        // 300-cycle window with constant spikes saturates at 255.
        window_len = WW'(300);
        base = cyc;
        expect_sample(255, 1, base + 301);
        for (int i = 0; i < 300; i++) step(1, 1);
        step(0, 0);
        repeat (3) step(0, 0);

        // Abandoned window: no sample, then a fresh window counts alone.
        window_len = WW'(10);
        for (int i = 0; i < 5; i++) step(1, 1);
        step(0, 1);
        repeat (12) step(0, 0);
        check("abandon_no_valid", int'(out_valid), 0);
        base = cyc;
        expect_sample(5, 2, base + 11);
        for (int i = 0; i < 10; i++) step(1, (i % 2) == 0);
        step(0, 0);
        repeat (3) step(0, 0);

        // Two windows of 8 with ready low: the second overwrites the first.
        out_ready  = 1'b0;
        window_len = WW'(8);
        base = cyc;
        for (int i = 0; i < 16; i++) begin
            if (i == 12) begin
                check("ovr_first_valid", int'(out_valid), 1);
                check("ovr_first_rate", int'(rate), 8);
                check("ovr_not_yet", int'(overrun), 0);
            end
            step(1, 1);
        end
        step(0, 0);
        check("ovr_set", int'(overrun), 1);
        check("ovr_rate", int'(rate), 8);
        check("ovr_valid", int'(out_valid), 1);
        expect_sample(8, 1, base + 17);
        out_ready = 1'b1;
        step(0, 0);
        check("ovr_valid_clear", int'(out_valid), 0);
        check("ovr_sticky", int'(overrun), 1);
        repeat (2) step(0, 0);

        // Synchronous reset while a sample is pending and a window runs.
        out_ready  = 1'b0;
        window_len = WW'(4);
        for (int i = 0; i < 6; i++) step(1, 1);
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_rate", int'(rate), 4);
        rst_n = 1'b0;
        step(1, 1);
        check("rst_valid", int'(out_valid), 0);
        check("rst_rate", int'(rate), 0);
        check("rst_overrun", int'(overrun), 0);
`ifdef SPIKE_RATE_DECODER_ISI_EN
        check("rst_min_isi", int'(min_isi), 255);
`endif
        rst_n = 1'b1;
        step(0, 0);

        // After reset the decoder starts clean from IDLE.
        out_ready = 1'b1;
        base = cyc;
        expect_sample(3, 1, base + 5);
        step(1, 1);
        step(1, 1);
        step(1, 0);
        step(1, 1);
        step(0, 0);
        repeat (4) step(0, 0);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
